disp_mux_scan: RTL
==================

DISP_MUX_SCAN -- requirements
Module: disp_mux_scan

Interface
REQ-001 Parameter CH, default 8, meaning number of display channels (legal 2..16).
REQ-002 Parameter DW, default 32, meaning display data width per channel.
REQ-003 Parameter MW, default 8, meaning blink/point mask width per channel.
REQ-004 Parameter DWW, default 24, meaning dwell-count width.
REQ-005 Parameter INIT_DATA, default 32'hAA5555AA (truncated/zero-extended to DW), meaning channel-0 reset pattern.
REQ-006 Derived SW = clog2(CH), meaning select width.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-009 en  input  1  capture strobe for channel 0 holding registers.
REQ-010 test  input  SW  manual channel select.
REQ-011 mode  input  1  0 = manual, 1 = auto-scan.
REQ-012 dwell  input  DWW  cycles per channel in auto-scan, minus one.
REQ-013 data_in  input  CH*DW  channel k at [k*DW +: DW].
REQ-014 les_in  input  CH*MW  blink masks, channel k at [k*MW +: MW].
REQ-015 point_in  input  CH*MW  point masks, same packing.
REQ-016 disp_num  output  DW  registered selected display data.
REQ-017 le_out  output  MW  registered selected blink mask.
REQ-018 point_out  output  MW  registered selected point mask.
REQ-019 cur_ch  output  SW  currently displayed channel.
REQ-020 ch_stb  output  1  one-cycle pulse when cur_ch changes.

Function
REQ-021 Channel 0 SHALL be served from holding registers (cpu_data, cpu_blink, cpu_point) loaded from slice 0 of data_in/les_in/point_in on any clk edge with en=1, held otherwise; channels 1..CH-1 SHALL be taken live from their slices.
REQ-022 Manual mode: cur_ch SHALL load test each cycle; test >= CH SHALL clamp to CH-1.
REQ-023 Auto mode: dwell counter SHALL count 0..dwell; on the cycle it equals dwell, cur_ch SHALL advance by one (CH-1 wraps to 0) and the counter SHALL clear; dwell=0 advances every cycle.
REQ-024 Manual->auto transition: counter SHALL clear and scanning SHALL start from the current cur_ch.
REQ-025 Auto->manual transition: counter SHALL clear and cur_ch SHALL load test on the next edge.
REQ-026 dwell changed mid-count: new value SHALL apply immediately; counter > new dwell SHALL advance on the next edge.
REQ-027 Outputs SHALL be registered from the cur_ch register: latency test->outputs 2 cycles, cur_ch->outputs 1 cycle.
REQ-028 en coincident with cur_ch=0: the captured value SHALL appear on outputs one cycle after the capture edge.
REQ-029 ch_stb SHALL be 1 exactly in the cycle in which cur_ch holds a value different from its previous value; no pulse when the value is unchanged.

Reset
REQ-030 rst low SHALL asynchronously set cpu_data=INIT_DATA, cpu_blink=all ones, cpu_point=0, cur_ch=0, counter=0, ch_stb=0, disp_num=INIT_DATA, le_out=all ones, point_out=0.
REQ-031 Reset during auto-scan SHALL abort the scan; after release, behaviour SHALL restart from channel 0 with counter 0.

Configuration
REQ-032 Macro DISP_MUX_AUTOSCAN_EN defined: auto-scan logic, dwell counter and mode/dwell inputs SHALL be active.
REQ-033 Macro undefined: mode and dwell SHALL be ignored, no counter SHALL be built, and behaviour SHALL equal manual mode.

Structure
REQ-034 Shared package disp_pkg SHALL hold the clog2 function, the INIT_DATA default and mode encodings (MODE_MANUAL=0, MODE_AUTO=1).
REQ-035 Sub-module disp_scan_ctrl SHALL own cur_ch, dwell counter and ch_stb; the datapath mux and holding registers SHALL stay in disp_mux_scan.

Verification
REQ-036 Reset release, no en -> disp_num=32'hAA5555AA, le_out=8'hFF, point_out=8'h00, cur_ch=0.
REQ-037 data_in slice0=32'h12345678, en pulse, test=0 -> disp_num=32'h12345678 one cycle after capture; slice0 then changed to 32'h0 with en=0 -> disp_num stays 32'h12345678.
REQ-038 Manual, test 0->3, slice3=32'hCAFE0003 -> cur_ch=3 and ch_stb=1 after 1 cycle, disp_num=32'hCAFE0003 after 2 cycles.
REQ-039 Auto, dwell=2 -> cur_ch sequence 0,0,0,1,1,1,...,7,7,7,0 with ch_stb on each change, including the 7->0 wrap.
REQ-040 CH=5 build, test=7 -> cur_ch=4; rst low mid auto-scan at cur_ch=3 -> cur_ch=0, outputs at REQ-030 values immediately, without a clock edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the display scan multiplexer.
// Build option: define DISP_MUX_AUTOSCAN_EN to enable auto-scan mode.
package disp_pkg;

  // Channel-0 holding register reset pattern.
  localparam logic [31:0] INIT_DATA_DEF = 32'hAA5555AA;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } disp_mode_e;

  // Ceiling log2, never less than 1 so a select port always has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl.sv
// Channel select control: manual select with clamping and, when
// DISP_MUX_AUTOSCAN_EN is defined, dwell-timed auto-scan. Owns cur_ch,
// the dwell counter and the channel-change strobe.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned CH  = 8,
  parameter int unsigned DWW = 24,
  localparam int unsigned SW = clog2(CH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SW-1:0]  test,
  input  logic           mode,
  input  logic [DWW-1:0] dwell,
  output logic [SW-1:0]  cur_ch,
  output logic           ch_stb
);

  localparam logic [SW-1:0] MaxCh = SW'(CH - 1);

  logic [SW-1:0] cur_ch_q, cur_ch_d;
  logic [SW-1:0] test_clamped;
  logic          ch_stb_q;

  assign test_clamped = (test > MaxCh) ? MaxCh : test;

`ifdef DISP_MUX_AUTOSCAN_EN
  logic [DWW-1:0] cnt_q, cnt_d;

  // Next channel and dwell count; manual mode keeps the counter at zero so
  // entering auto starts a fresh dwell from the current channel.
  always_comb begin
    cur_ch_d = test_clamped;
    cnt_d    = '0;
    if (mode == MODE_AUTO) begin
      cur_ch_d = cur_ch_q;
      // >= so a dwell lowered below the running count advances at once.
      if (cnt_q >= dwell) begin
        cnt_d    = '0;
        cur_ch_d = (cur_ch_q == MaxCh) ? '0 : cur_ch_q + SW'(1);
      end else begin
        cnt_d = cnt_q + DWW'(1);
      end
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, dwell};

  // Manual select only.
  always_comb begin
    cur_ch_d = test_clamped;
  end
`endif

  // Channel register and change strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ch_q <= '0;
      ch_stb_q <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      ch_stb_q <= (cur_ch_d != cur_ch_q);
    end
  end

  assign cur_ch = cur_ch_q;
  assign ch_stb = ch_stb_q;

endmodule

// File: rtl/disp_mux_scan.sv
// Display multiplexer: channel 0 comes from CPU holding registers, the
// other channels live from their input slices; the selected channel is
// registered onto the outputs. Auto-scan is built only when
// DISP_MUX_AUTOSCAN_EN is defined.
module disp_mux_scan
  import disp_pkg::*;
#(
  parameter int unsigned CH        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned MW        = 8,
  parameter int unsigned DWW       = 24,
  parameter logic [31:0] INIT_DATA = INIT_DATA_DEF,
  localparam int unsigned SW       = clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SW-1:0]    test,
  input  logic             mode,
  input  logic [DWW-1:0]   dwell,
  input  logic [CH*DW-1:0] data_in,
  input  logic [CH*MW-1:0] les_in,
  input  logic [CH*MW-1:0] point_in,
  output logic [DW-1:0]    disp_num,
  output logic [MW-1:0]    le_out,
  output logic [MW-1:0]    point_out,
  output logic [SW-1:0]    cur_ch,
  output logic             ch_stb
);

  localparam logic [DW-1:0] InitVal = DW'(INIT_DATA);

  logic [DW-1:0] cpu_data_q;
  logic [MW-1:0] cpu_blink_q, cpu_point_q;
  logic [DW-1:0] sel_data, disp_num_q;
  logic [MW-1:0] sel_blink, sel_point, le_out_q, point_out_q;
  logic [SW-1:0] cur_ch_w;

  disp_scan_ctrl #(
    .CH  (CH),
    .DWW (DWW)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .test   (test),
    .mode   (mode),
    .dwell  (dwell),
    .cur_ch (cur_ch_w),
    .ch_stb (ch_stb)
  );

  // Channel 0 holding registers, loaded from slice 0 on en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_data_q  <= InitVal;
      cpu_blink_q <= '1;
      cpu_point_q <= '0;
    end else if (en) begin
      cpu_data_q  <= data_in[DW-1:0];
      cpu_blink_q <= les_in[MW-1:0];
      cpu_point_q <= point_in[MW-1:0];
    end
  end

  // Select the displayed channel from the registered channel number.
  always_comb begin
    sel_data  = cpu_data_q;
    sel_blink = cpu_blink_q;
    sel_point = cpu_point_q;
    if (cur_ch_w != '0) begin
      sel_data  = data_in[int'(cur_ch_w)*DW +: DW];
      sel_blink = les_in[int'(cur_ch_w)*MW +: MW];
      sel_point = point_in[int'(cur_ch_w)*MW +: MW];
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_num_q  <= InitVal;
      le_out_q    <= '1;
      point_out_q <= '0;
    end else begin
      disp_num_q  <= sel_data;
      le_out_q    <= sel_blink;
      point_out_q <= sel_point;
    end
  end

  assign disp_num  = disp_num_q;
  assign le_out    = le_out_q;
  assign point_out = point_out_q;
  assign cur_ch    = cur_ch_w;

endmodule
